game_area_store: RTL

- Storage and update engine for the 20-row x 12-column Tetris playfield. One bit per cell; row 0 is the top row, bit 11 is the leftmost column.
- Serves the renderer's synchronous row-read port: the renderer drives the row address and this block returns the row data.
- Accepts single-cycle row write/merge commands from game logic.
- Runs multi-cycle clear-all and line-collapse sequences.

---
 rtl/game_area_store.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/game_area_store.sv
// Tetris playfield store: 20x12 bit rows, registered row-read port, row write/merge,
// clear-all and line-collapse sequencer. Define GAME_AREA_FULLMAP_EN to add the full_map output.
module game_area_store #(
  parameter int              ROWS     = 20,
  parameter int              COLS     = 12,
  parameter logic [COLS-1:0] FULL_ROW = 12'hFFF
) (
  input  logic            vga_clk,
  input  logic            rst,
  input  logic [4:0]      rd_addr,
  output logic [COLS-1:0] rd_data,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [4:0]      cmd_row,
  input  logic [COLS-1:0] cmd_data,
  output logic            done,
  output logic [2:0]      rows_cleared
`ifdef GAME_AREA_FULLMAP_EN
  ,
  output logic [ROWS-1:0] full_map
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_COLLAPSE,
    S_FILL,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_CLEAR    = 2'b00,
    OP_WRITE    = 2'b01,
    OP_MERGE    = 2'b10,
    OP_COLLAPSE = 2'b11
  } op_e;

  localparam logic [4:0] ROWS_W   = 5'(ROWS);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  state_e          state_q, state_d;
  logic [COLS-1:0] mem_q [ROWS];
  logic [COLS-1:0] mem_d [ROWS];
  logic [4:0]      ptr_q, ptr_d;
  logic [4:0]      src_q, src_d;
  logic [4:0]      dst_q, dst_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [COLS-1:0] rd_data_q, rd_data_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            done_q, done_d;
  logic [2:0]      rows_cleared_q, rows_cleared_d;

  logic accept;
  logic src_last;
  logic dst_last;
  logic src_full;

  assign accept   = cmd_valid && cmd_ready_q;
  // Explicit last-row flags keep the down-counting pointers from ever wrapping past 0.
  assign src_last = (src_q == 5'd0);
  assign dst_last = (dst_q == 5'd0);
  assign src_full = (mem_q[src_q] == FULL_ROW);

  // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    mem_d          = mem_q;
    ptr_d          = ptr_q;
    src_d          = src_q;
    dst_d          = dst_q;
    cnt_d          = cnt_q;
    rows_cleared_d = rows_cleared_q;
    // Reads sample the pre-edge contents, so a same-edge write is not visible yet.
    rd_data_d      = (rd_addr < ROWS_W) ? mem_q[rd_addr] : '0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          unique case (op_e'(cmd_op))
            OP_WRITE: begin
              if (cmd_row < ROWS_W) mem_d[cmd_row] = cmd_data;
              state_d = S_DONE;
            end
            OP_MERGE: begin
              if (cmd_row < ROWS_W) mem_d[cmd_row] = mem_q[cmd_row] | cmd_data;
              state_d = S_DONE;
            end
            OP_CLEAR: begin
              ptr_d   = 5'd0;
              state_d = S_CLEAR;
            end
            OP_COLLAPSE: begin
              src_d   = LAST_ROW;
              dst_d   = LAST_ROW;
              cnt_d   = 5'd0;
              state_d = S_COLLAPSE;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end

      S_CLEAR: begin
        mem_d[ptr_q] = '0;
        if (ptr_q == LAST_ROW) state_d = S_DONE;
        else                   ptr_d   = ptr_q + 5'd1;
      end

      S_COLLAPSE: begin
        // Full rows are dropped; surviving rows slide down to dst, leaving dst above them.
        if (src_full) begin
          cnt_d = cnt_q + 5'd1;
        end else begin
          if (src_q != dst_q) mem_d[dst_q] = mem_q[src_q];
          if (!dst_last)      dst_d        = dst_q - 5'd1;
        end
        if (src_last) begin
          if (cnt_d != 5'd0) begin
            state_d = S_FILL;
          end else begin
            state_d        = S_DONE;
            rows_cleared_d = cnt_d[2:0];
          end
        end else begin
          src_d = src_q - 5'd1;
        end
      end

      S_FILL: begin
        mem_d[dst_q] = '0;
        if (dst_last) begin
          state_d        = S_DONE;
          rows_cleared_d = cnt_q[2:0];
        end else begin
          dst_d = dst_q - 5'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE) || (state_d == S_DONE);
    done_d      = (state_d == S_DONE);
  end

  // NOTE: the row array is reset on purpose; a mid-sequence reset must leave an empty field, so it cannot map to a reset-less RAM.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      mem_q          <= '{default: '0};
      ptr_q          <= 5'd0;
      src_q          <= 5'd0;
      dst_q          <= 5'd0;
      cnt_q          <= 5'd0;
      rd_data_q      <= '0;
      cmd_ready_q    <= 1'b1;
      done_q         <= 1'b0;
      rows_cleared_q <= 3'd0;
    end else begin
      state_q        <= state_d;
      mem_q          <= mem_d;
      ptr_q          <= ptr_d;
      src_q          <= src_d;
      dst_q          <= dst_d;
      cnt_q          <= cnt_d;
      rd_data_q      <= rd_data_d;
      cmd_ready_q    <= cmd_ready_d;
      done_q         <= done_d;
      rows_cleared_q <= rows_cleared_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign cmd_ready    = cmd_ready_q;
  assign done         = done_q;
  assign rows_cleared = rows_cleared_q;

`ifdef GAME_AREA_FULLMAP_EN
  // One bit per row flagging a completed line, one cycle behind the row contents.
  logic [ROWS-1:0] full_map_q, full_map_d;

  always_comb begin
    full_map_d = '0;
    for (int i = 0; i < ROWS; i++) full_map_d[i] = (mem_q[i] == FULL_ROW);
  end

  always_ff @(posedge vga_clk) begin
    if (rst) full_map_q <= '0;
    else     full_map_q <= full_map_d;
  end

  assign full_map = full_map_q;
`endif

endmodule
